// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt controller: CSR addresses,
// trap instruction encodings, cause codes, FSM state encoding and mstatus helpers.
package clint_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MSTATUS = 3'd2,
    S_W_MCAUSE  = 3'd3,
    S_MRET_W    = 3'd4,
    S_ASSERT    = 3'd5
  } clint_state_e;

  // Trap entry: MPIE takes the old MIE, MIE is cleared.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
    logic [31:0] r;
    r           = ms;
    r[MPIE_BIT] = ms[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // Trap return: MIE restored from MPIE, MPIE set.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
    logic [31:0] r;
    r           = ms;
    r[MIE_BIT]  = ms[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt controller: sequences the mepc/mstatus/mcause CSR writes
// for traps and interrupts, the mstatus restore for mret, then one PC redirect.
//
// state       | meaning
// S_IDLE      | waiting for ecall/ebreak, mret or an enabled interrupt
// S_W_MEPC    | writing the exception PC to mepc
// S_W_MSTATUS | writing mstatus with MPIE<=MIE, MIE<=0
// S_W_MCAUSE  | writing mcause, sampling mtvec as the redirect target
// S_MRET_W    | writing mstatus with MIE<=MPIE, MPIE<=1, sampling mepc
// S_ASSERT    | one-cycle redirect of the PC to the sampled target
module clint
  import clint_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_enable_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stallreq_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  clint_state_e state_q;
  logic [31:0]  epc_q;
  logic [31:0]  cause_q;
  logic [31:0]  target_q;
  logic [31:0]  mstatus_q;

  logic is_ecall;
  logic is_ebreak;
  logic is_sync;
  logic is_mret;
  logic is_irq;
  logic entry_ok;
  logic take_entry;

  always_comb begin
    is_ecall   = (inst_i == INST_ECALL);
    is_ebreak  = (inst_i == INST_EBREAK);
    is_sync    = is_ecall || is_ebreak;
    is_mret    = (inst_i == INST_MRET);
    is_irq     = irq_i && csr_mstatus_i[MIE_BIT];
    entry_ok   = (state_q == S_IDLE) && !stallreq_i;
    // Reset wins over a pending entry so hold stays low while rst_i is held.
    take_entry = entry_ok && !rst_i && (is_sync || is_mret || is_irq);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      target_q  <= '0;
      mstatus_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (entry_ok) begin
            if (is_sync) begin
              epc_q     <= inst_addr_i;
              cause_q   <= is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
              mstatus_q <= csr_mstatus_i;
              state_q   <= S_W_MEPC;
            end else if (is_mret) begin
              mstatus_q <= csr_mstatus_i;
              state_q   <= S_MRET_W;
            end else if (is_irq) begin
              epc_q     <= jump_enable_i ? jump_addr_i : inst_addr_i;
              cause_q   <= CAUSE_EXT_IRQ;
              mstatus_q <= csr_mstatus_i;
              state_q   <= S_W_MEPC;
            end
          end
        end
        S_W_MEPC:    state_q <= S_W_MSTATUS;
        S_W_MSTATUS: state_q <= S_W_MCAUSE;
        S_W_MCAUSE: begin
          target_q <= csr_mtvec_i;
          state_q  <= S_ASSERT;
        end
        S_MRET_W: begin
          target_q <= csr_mepc_i;
          state_q  <= S_ASSERT;
        end
        S_ASSERT:    state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    unique case (state_q)
      S_W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc_q;
      end
      S_W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstatus_on_trap(mstatus_q);
      end
      S_W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      S_MRET_W: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstatus_on_mret(mstatus_q);
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = target_q;
      end
      default: ;
    endcase
    hold_o = (state_q != S_IDLE) || take_entry;
  end

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: directed trap/mret/irq/reset scenarios followed by
// random traffic, checked against a cycle-level reference model.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        irq_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic        jump_enable_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        stallreq_i = 1'b0;
  logic [31:0] csr_mtvec_i = '0;
  logic [31:0] csr_mepc_i = '0;
  logic [31:0] csr_mstatus_i = '0;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        hold_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  clint dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .irq_i         (irq_i),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .jump_enable_i (jump_enable_i),
    .jump_addr_i   (jump_addr_i),
    .stallreq_i    (stallreq_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .csr_mstatus_i (csr_mstatus_i),
    .csr_we_o      (csr_we_o),
    .csr_waddr_o   (csr_waddr_o),
    .csr_wdata_o   (csr_wdata_o),
    .hold_o        (hold_o),
    .int_assert_o  (int_assert_o),
    .int_addr_o    (int_addr_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int NCYC = 2048;

  typedef struct {
    int          cyc;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        ia;
    logic [31:0] iaddr;
  } ev_t;

  ev_t         exp_q[$];
  bit          hold_exp[int];
  logic [31:0] mtvec_arr[NCYC];
  logic [31:0] mepc_arr[NCYC];
  int          cyc = -1;
  int          free_c = 0;
  bit          mon_on = 1'b0;
  int          checks = 0;
  int          failures = 0;

  function automatic ev_t wr(input int c, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.we = 1'b1; e.waddr = a; e.wdata = d; e.ia = 1'b0; e.iaddr = '0;
    return e;
  endfunction

  function automatic ev_t jmp(input int c, input logic [31:0] t);
    ev_t e;
    e.cyc = c; e.we = 1'b0; e.waddr = '0; e.wdata = '0; e.ia = 1'b1; e.iaddr = t;
    return e;
  endfunction

  // One clock cycle of stimulus plus the reference decision for that cycle.
  task automatic drv(input logic rst, input logic irq, input logic [31:0] inst,
                     input logic [31:0] addr, input logic je, input logic [31:0] ja,
                     input logic stall, input logic [31:0] ms);
    bit          busy;
    bit          entry;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] mie;
    logic [31:0] mpie;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    rst_i = rst; irq_i = irq; inst_i = inst; inst_addr_i = addr;
    jump_enable_i = je; jump_addr_i = ja; stallreq_i = stall; csr_mstatus_i = ms;
    csr_mtvec_i = mtvec_arr[cyc];
    csr_mepc_i  = mepc_arr[cyc];
    busy  = (cyc < free_c);
    entry = 1'b0;
    if (rst) begin
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      free_c = cyc + 1;
    end else if (!busy && !stall) begin
      mie  = (ms >> 3) & 32'd1;
      mpie = (ms >> 7) & 32'd1;
      if (inst == ECALL || inst == EBREAK || (irq && mie == 32'd1)) begin
        entry = 1'b1;
        if (inst == ECALL) begin
          cause = 32'd11; epc = addr;
        end else if (inst == EBREAK) begin
          cause = 32'd3; epc = addr;
        end else if (inst == MRET) begin
          cause = 32'd0; epc = 32'd0; entry = 1'b0;
        end else begin
          cause = 32'h8000_000B; epc = je ? ja : addr;
        end
        if (entry) begin
          exp_q.push_back(wr(cyc + 1, 12'h341, epc));
          exp_q.push_back(wr(cyc + 2, 12'h300, (ms & ~32'h88) | (mie << 7)));
          exp_q.push_back(wr(cyc + 3, 12'h342, cause));
          exp_q.push_back(jmp(cyc + 4, mtvec_arr[cyc + 3]));
          free_c = cyc + 5;
        end
      end
      if (!entry && inst == MRET) begin
        entry = 1'b1;
        exp_q.push_back(wr(cyc + 1, 12'h300, (ms & ~32'h88) | (mpie << 3) | 32'h80));
        exp_q.push_back(jmp(cyc + 2, mepc_arr[cyc + 1]));
        free_c = cyc + 3;
      end
    end
    hold_exp[cyc] = busy || entry;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, NOP, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or redirect.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_on && cyc >= 1) begin
        if (csr_we_o || int_assert_o) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output cyc=%0d got we=%0b waddr=%h wdata=%h assert=%0b addr=%h",
                     cyc, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.we !== csr_we_o || e.waddr !== csr_waddr_o ||
                e.wdata !== csr_wdata_o || e.ia !== int_assert_o || e.iaddr !== int_addr_o) begin
              failures++;
              $display("FAIL output_event cyc=%0d got we=%0b waddr=%h wdata=%h assert=%0b addr=%h exp cyc=%0d we=%0b waddr=%h wdata=%h assert=%0b addr=%h",
                       cyc, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o,
                       e.cyc, e.we, e.waddr, e.wdata, e.ia, e.iaddr);
            end
          end
        end else begin
          if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            failures++;
            e = exp_q.pop_front();
            $display("FAIL missing_event cyc=%0d got none exp cyc=%0d waddr=%h wdata=%h assert=%0b addr=%h",
                     cyc, e.cyc, e.waddr, e.wdata, e.ia, e.iaddr);
          end
          checks++;
          if (csr_waddr_o !== '0 || csr_wdata_o !== '0 || int_addr_o !== '0 ||
              csr_we_o !== 1'b0 || int_assert_o !== 1'b0) begin
            failures++;
            $display("FAIL quiet_outputs cyc=%0d got waddr=%h wdata=%h addr=%h exp all zero",
                     cyc, csr_waddr_o, csr_wdata_o, int_addr_o);
          end
        end
        checks++;
        if (!hold_exp.exists(cyc) || hold_o !== hold_exp[cyc]) begin
          failures++;
          $display("FAIL hold cyc=%0d got %0b exp %0b", cyc, hold_o,
                   hold_exp.exists(cyc) ? hold_exp[cyc] : 1'b0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      mtvec_arr[i] = (i < 120) ? 32'h200 : $urandom;
      mepc_arr[i]  = (i < 120) ? 32'h104 : $urandom;
    end
    mon_on = 1'b1;
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b1, ECALL, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8);
    idle(2);
    // ecall at 0x100 with MIE set
    drv(1'b0, 1'b0, ECALL, 32'h100, 1'b0, 32'h0, 1'b0, 32'h8);
    idle(6);
    // interrupt while execute redirects
    drv(1'b0, 1'b1, NOP, 32'h120, 1'b1, 32'h340, 1'b0, 32'h8);
    idle(6);
    // interrupt masked
    drv(1'b0, 1'b1, NOP, 32'h124, 1'b1, 32'h340, 1'b0, 32'h0);
    idle(3);
    // mret restoring MIE from MPIE
    drv(1'b0, 1'b0, MRET, 32'h128, 1'b0, 32'h0, 1'b0, 32'h80);
    idle(4);
    // interrupt held off by stall, then taken
    for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, NOP, 32'h130, 1'b0, 32'h0, 1'b1, 32'h8);
    drv(1'b0, 1'b1, NOP, 32'h134, 1'b0, 32'h0, 1'b0, 32'h8);
    idle(6);
    // ecall and interrupt together: sync trap wins
    drv(1'b0, 1'b1, ECALL, 32'h140, 1'b1, 32'h500, 1'b0, 32'h8);
    idle(6);
    // ebreak, then reset during the mstatus write
    drv(1'b0, 1'b0, EBREAK, 32'h150, 1'b0, 32'h0, 1'b0, 32'h8);
    idle(1);
    drv(1'b1, 1'b0, NOP, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(6);
    // back-to-back entry right after a redirect
    drv(1'b0, 1'b0, MRET, 32'h160, 1'b0, 32'h0, 1'b0, 32'h0);
    drv(1'b0, 1'b1, NOP, 32'h164, 1'b0, 32'h0, 1'b0, 32'h8);
    drv(1'b0, 1'b0, ECALL, 32'h168, 1'b0, 32'h0, 1'b0, 32'h8);
    idle(8);
    for (int n = 0; n < 1200; n++) begin
      int          r;
      logic [31:0] inst;
      r = $urandom_range(99);
      if (r < 10)      inst = ECALL;
      else if (r < 15) inst = EBREAK;
      else if (r < 23) inst = MRET;
      else             inst = $urandom;
      drv($urandom_range(99) < 2, $urandom_range(99) < 30, inst, $urandom,
          $urandom_range(99) < 30, $urandom, $urandom_range(99) < 20, $urandom);
    end
    idle(8);
    @(posedge clk);
    #1;
    mon_on = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending events exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
